// File: rtl/wb_host_master.sv
// Wishbone classic (B3) single-beat initiator with per-cycle timeout.
// Ports:
//   wb_clk_i, wb_rst_i            clock, async active-high reset
//   cmd_*                         command stream in (valid/ready)
//   rsp_*                         response stream out (valid/ready)
//   wbm_*                         32-bit Wishbone initiator port
// One command in flight at a time. Every accepted command yields exactly
// one response (ack, err or timeout) unless reset intervenes.
module wb_host_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  // Counter is at least 1 bit so TIMEOUT = 0 (disabled) still elaborates.
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;

  // Single-process FSM; every output is a register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // ready comes up one edge after reset release, then stays up
          if (!cmd_ready_o) begin
            cmd_ready_o <= 1'b1;
          end else if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            wbm_we_o    <= cmd_we_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_sel_o   <= cmd_sel_i;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            tmo_cnt     <= '0;
            state       <= BUS;
          end
        end
        BUS: begin
          if (wbm_err_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_err_o   <= 1'b1;
            rsp_dat_o   <= '0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (TIMEOUT != 0 && tmo_cnt == LAST) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_err_o   <= 1'b1;
            rsp_dat_o   <= '0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master (TIMEOUT = 8): directed cases from
// the bring-up plan plus randomized transactions against a reference model.
module tb_wb_host_master;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o, dat_i;
  logic [3:0]  sel;
  logic        ack, err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_host_master #(.TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction. Called and returns at a falling edge. w = stb cycles
  // the slave waits before acking; rdelay = cycles rsp_ready is held low.
  // cmd_valid is kept high throughout to prove no second command slips in.
  task automatic txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                     input logic [3:0] t_sel, input int w, input logic [31:0] rd,
                     input logic err_en, input int rdelay);
    int t;
    int len;
    int bad;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_len;
    logic [31:0] held_dat;
    logic        held_err;
    // reference model: outcome from wait count and slave behaviour
    exp_err = (w >= TMO) || err_en;
    exp_dat = (exp_err || t_we) ? 32'h0 : rd;
    exp_len = (w >= TMO) ? TMO : w + 1;

    cmd_valid = 1'b1; cmd_we = t_we; cmd_adr = t_adr; cmd_dat = t_dat; cmd_sel = t_sel;
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    len = 0; bad = 0;
    while (cyc && len < 40) begin
      len++;
      if (stb !== 1'b1 || we !== t_we || adr !== t_adr || dat_o !== t_dat ||
          sel !== t_sel || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) bad++;
      if (len == w + 1) begin
        ack = 1'b1; err = err_en; dat_i = rd;
      end else begin
        ack = 1'b0; err = 1'b0; dat_i = $urandom;
      end
      @(negedge clk);
    end
    ack = 1'b0; err = 1'b0;
    check("cyc_len", 32'(len), 32'(exp_len));
    check("bus_stable", 32'(bad), 32'd0);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_dat", rsp_dat, exp_dat);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    held_dat = rsp_dat; held_err = rsp_err;

    // stray acks/errs while waiting for rsp_ready must be ignored
    bad = 0;
    for (int i = 0; i < rdelay; i++) begin
      ack = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      err = 1'($urandom_range(0, 1));
      dat_i = $urandom;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dat !== held_dat || rsp_err !== held_err ||
          cmd_ready !== 1'b0 || cyc !== 1'b0) bad++;
    end
    ack = 1'b0; err = 1'b0;
    if (rdelay > 0) check("rsp_hold", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("rsp_done_valid", 32'(rsp_valid), 32'd0);
    check("rsp_done_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int t;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; dat_i = '0; ack = 1'b0; err = 1'b0;
    #1;
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp", {rsp_dat[30:0], rsp_err}, 32'd0);
    check("rst_adr", adr, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_ready_lo", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("post_rst_ready_hi", 32'(cmd_ready), 32'd1);

    // zero-wait read
    txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 1'b0, 0);
    // write with 4 wait states
    txn(1'b1, 32'h3000_0010, 32'h1234_5678, 4'h3, 4, 32'hDEAD_BEEF, 1'b0, 0);
    // timeout, late ack ignored during the response wait
    txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 20, 32'h5555_AAAA, 1'b0, 4);
    // ack and err together: err wins
    txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 1, 32'hFFFF_FFFF, 1'b1, 0);
    // response backpressure for 10 cycles
    txn(1'b0, 32'h3000_0040, 32'h0, 4'hC, 2, 32'h0BAD_F00D, 1'b0, 10);
    // last cycle before timeout still acks normally
    txn(1'b0, 32'h3000_0044, 32'h0, 4'h1, TMO - 1, 32'h7777_1111, 1'b0, 0);

    // reset in the middle of a bus cycle
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0050; cmd_sel = 4'hF;
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_cyc", 32'(cyc), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("midrst_cyc", 32'(cyc), 32'd0);
    check("midrst_stb", 32'(stb), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_no_rsp", 32'(rsp_valid), 32'd0);
    check("after_rst_ready", 32'(cmd_ready), 32'd1);
    txn(1'b0, 32'h3000_0060, 32'h0, 4'hF, 0, 32'h1357_9BDF, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int w;
      w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TMO, TMO + 3))
                                      : int'($urandom_range(0, TMO - 1));
      txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), w,
          $urandom, ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Wishbone classic (B3, non-pipelined) initiator that turns a single-beat command/response stream into bus cycles on a 32-bit Wishbone port. It is the initiating end of the `wbs_*` interface the user-project wrapper exposes. It sits in the test and bring-up fabric, driven by a command source such as a UART or JTAG debug bridge. A per-transaction timeout guarantees every accepted command produces exactly one response, even when no responder acknowledges.

## Interface
- `TIMEOUT`, default 255: number of cycles a bus cycle may stay open before it is aborted. The value 0 disables the timeout.
- `wb_clk_i`  in  1  clock; all logic is on the rising edge.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  command accepted when both valid and ready are high.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_adr_i`  in  32  byte address.
- `cmd_dat_i`  in  32  write data.
- `cmd_sel_i`  in  4  byte lanes.
- `rsp_valid_o`  out  1  response available.
- `rsp_ready_i`  in  1  response consumed when both valid and ready are high.
- `rsp_dat_o`  out  32  read data; 0 for writes and for error responses.
- `rsp_err_o`  out  1  1 = bus error or timeout.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone control signals.
- `wbm_adr_o`  out  32, `wbm_dat_o`  out  32, `wbm_sel_o`  out  4.
- `wbm_dat_i`  in  32, `wbm_ack_i`  in  1, `wbm_err_i`  in  1.

## Operation
- FSM states: IDLE, BUS, RESP. Every output is driven from registers.
- **IDLE**
  - `cmd_ready_o` = 1 in IDLE only.
  - On a command handshake: latch we, adr, dat and sel onto the `wbm_*` outputs, set cyc = stb = 1, clear the timeout counter, go to BUS.
- **BUS**
  - cyc, stb and all `wbm_*` address/data/control outputs are held stable.
  - On a sampled `wbm_err_i`: cyc = stb = 0, rsp_err = 1, rsp_dat = 0, go to RESP.
  - Else on a sampled `wbm_ack_i`: cyc = stb = 0, rsp_err = 0, go to RESP. rsp_dat = `wbm_dat_i` for a read, 0 for a write.
  - If ack and err are high together, err wins.
  - Else, if `TIMEOUT` != 0 and the counter equals `TIMEOUT`-1: abort. cyc = stb = 0, rsp_err = 1, rsp_dat = 0, go to RESP.
  - Otherwise the counter increments. It is `$clog2(TIMEOUT+1)` bits wide and never wraps, because the abort fires first.
- **RESP**
  - `rsp_valid_o` = 1 and the response fields are held.
  - On a response handshake: `rsp_valid_o` = 0, go to IDLE.
  - `rsp_ready_i` may stay low indefinitely; the command side stays stalled until it rises.
- `wbm_ack_i`/`wbm_err_i` outside BUS are ignored.
- `wbm_we_o`, `wbm_adr_o`, `wbm_dat_o` and `wbm_sel_o` keep their last values after a cycle ends. They are don't-care while cyc = 0.
- At most one outstanding transaction; no pipelining.

## Timing
- Reset values: all outputs 0, including `cmd_ready_o`. FSM in IDLE. `cmd_ready_o` rises on the first clock edge after reset deasserts.
- Reset mid-operation: cyc and stb drop asynchronously. The response is discarded. No response is ever issued for that command.
- Command handshake at edge E0 → cyc/stb high from E0.
- Slave ack sampled at edge En, where n ≥ 1 → cyc/stb low and `rsp_valid_o` high from En.
- Minimum command-to-response latency: 1 cycle, i.e. the slave acks in the first stb cycle.
- Response handshake at edge Er → `cmd_ready_o` high from Er.
- Next command accepted at Er+1 at the earliest. Back-to-back throughput is one transaction per 3 cycles with a zero-wait slave.
- Timeout: with no ack, cyc stays high for exactly `TIMEOUT` cycles. The cycle is aborted at edge E0+`TIMEOUT`.

## Test plan
- **Zero-wait read:** cmd read adr 0x3000_0004, sel 0xF. Slave acks in the first stb cycle with 0xCAFE_F00D. Required: cyc high for exactly 1 cycle; rsp_valid one cycle later with dat 0xCAFE_F00D, err 0.
- **Write with wait states:** cmd write adr 0x3000_0010, dat 0x1234_5678, sel 0x3. Slave acks after 4 cycles. Required: we/adr/dat/sel stable for all 4 cycles; rsp dat 0, err 0.
- **Timeout:** `TIMEOUT`=8, no ack. Required: cyc high for exactly 8 cycles, then rsp err 1, dat 0. An ack arriving 2 cycles after the abort is ignored.
- **Error priority:** ack and err asserted together on a read returning 0xFFFF_FFFF. Required: rsp err 1, dat 0.
- **Response backpressure:** `rsp_ready_i` held low 10 cycles while `cmd_valid_i` stays high. Required: `cmd_ready_o` stays 0 and the response is stable; the next command is accepted 1 cycle after the response handshake.
- **Reset mid-cycle:** assert `wb_rst_i` during BUS. Required: cyc/stb/rsp_valid drop to 0 without waiting for an edge. After release, a new read completes normally.
